// File: rtl/pc_src_pkg.sv
// Shared select encodings for the next-PC source mux.
package pc_src_pkg;

    typedef logic [1:0] pc_src_t;

    localparam pc_src_t PC_SRC_SEQ     = 2'd0;
    localparam pc_src_t PC_SRC_JUMP    = 2'd1;
    localparam pc_src_t PC_SRC_BRANCH  = 2'd2;
    localparam pc_src_t PC_SRC_ILLEGAL = 2'd3;

    localparam int unsigned PC_SRC_NUM = 3;

endpackage

// File: rtl/pc_src_mux3_if.sv
// Bus between fetch control (master) and the next-PC source mux (slave).
// PC_SRC_MUX_ALIGN_EN adds the registered misalign flag.
interface pc_src_mux3_if
    import pc_src_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    pc_src_t          sel;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_err;
`ifdef PC_SRC_MUX_ALIGN_EN
    logic             misalign;
`endif

    modport master (
        output en, sel, in0, in1, in2,
`ifdef PC_SRC_MUX_ALIGN_EN
        input  misalign,
`endif
        input  out, out_q, sel_err
    );

    modport slave (
        input  en, sel, in0, in1, in2,
`ifdef PC_SRC_MUX_ALIGN_EN
        output misalign,
`endif
        output out, out_q, sel_err
    );

endinterface

// File: rtl/pc_src_mux3_dec.sv
// Select decoder: sel -> one-hot source vector plus illegal flag.
// An illegal select falls back to the sequential source.
module pc_src_mux3_dec
    import pc_src_pkg::*;
(
    input  pc_src_t                    sel,
    output logic [PC_SRC_NUM-1:0]      onehot_c,
    output logic                       illegal_c
);

    // Decode select; illegal code steers to in0 so fetch keeps advancing
    always_comb begin
        onehot_c  = '0;
        illegal_c = 1'b0;
        case (sel)
            PC_SRC_SEQ:    onehot_c = 3'b001;
            PC_SRC_JUMP:   onehot_c = 3'b010;
            PC_SRC_BRANCH: onehot_c = 3'b100;
            default: begin
                onehot_c  = 3'b001;
                illegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pc_src_mux3.sv
// Three-way next-PC source selector: combinational out, stall-able
// registered out_q and sticky illegal-select flag.
// Optional macro PC_SRC_MUX_ALIGN_EN: word-align out and add misalign flag.
module pc_src_mux3
    import pc_src_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    pc_src_mux3_if.slave  bus
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [PC_SRC_NUM-1:0] onehot;
    logic                  illegal;
    logic [WIDTH-1:0]      out_raw;
    logic [WIDTH-1:0]      out_c;
    logic [WIDTH-1:0]      out_q_d;
    logic [WIDTH-1:0]      out_q;
    logic                  sel_err_d;
    logic                  sel_err_q;

    pc_src_mux3_dec u_dec (
        .sel       (bus.sel),
        .onehot_c  (onehot),
        .illegal_c (illegal)
    );

    // AND-OR data selection from the one-hot vector
    always_comb begin
        out_raw = ({WIDTH{onehot[0]}} & bus.in0)
                | ({WIDTH{onehot[1]}} & bus.in1)
                | ({WIDTH{onehot[2]}} & bus.in2);
`ifdef PC_SRC_MUX_ALIGN_EN
        out_c   = {out_raw[WIDTH-1:2], 2'b00};
`else
        out_c   = out_raw;
`endif
    end

    // Next register values: load on enable, flag is sticky
    always_comb begin
        out_q_d   = out_q;
        sel_err_d = sel_err_q;
        if (bus.en) begin
            out_q_d   = out_c;
            sel_err_d = sel_err_q | illegal;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= RST_Q;
            sel_err_q <= 1'b0;
        end else begin
            out_q     <= out_q_d;
            sel_err_q <= sel_err_d;
        end
    end

`ifdef PC_SRC_MUX_ALIGN_EN
    logic misalign_d;
    logic misalign_q;

    // Misalign reflects the low bits of the last loaded raw selection
    always_comb begin
        misalign_d = misalign_q;
        if (bus.en) begin
            misalign_d = |out_raw[1:0];
        end
    end

    // Misalign register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.misalign = misalign_q;
`endif

    assign bus.out     = out_c;
    assign bus.out_q   = out_q;
    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_pc_src_mux3.sv
// Self-checking bench for pc_src_mux3: directed plan items followed by
// randomized traffic against a behavioural reference model.
module tb_pc_src_mux3;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_src_mux3_if #(.WIDTH(W)) bus ();

    pc_src_mux3 #(.WIDTH(W), .RESET_VAL(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state
    logic [W-1:0] m_q;
    logic         m_err;
    logic         m_mis;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
        if (s == 2'd1) return b;
        if (s == 2'd2) return c;
        return a;
    endfunction

    function automatic logic [W-1:0] shape(input logic [W-1:0] v);
`ifdef PC_SRC_MUX_ALIGN_EN
        return v & ~W'(3);
`else
        return v;
`endif
    endfunction

    // Apply inputs and check the zero-latency output
    task automatic drive(input logic e, input logic [1:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
        bus.en  = e;
        bus.sel = s;
        bus.in0 = a;
        bus.in1 = b;
        bus.in2 = c;
        #1;
        check("out", bus.out, shape(pick(s, a, b, c)));
    endtask

    // One clock edge: advance the model with pre-edge inputs, then check registers
    task automatic step();
        logic [W-1:0] raw;
        @(posedge clk);
        raw = pick(bus.sel, bus.in0, bus.in1, bus.in2);
        if (bus.en) begin
            m_q   = shape(raw);
            m_err = m_err | (bus.sel == 2'd3);
            m_mis = (raw[1:0] != 2'b00);
        end
        #1;
        check("out_q", bus.out_q, m_q);
        check("sel_err", W'(bus.sel_err), W'(m_err));
`ifdef PC_SRC_MUX_ALIGN_EN
        check("misalign", W'(bus.misalign), W'(m_mis));
`endif
    endtask

    // Async reset mid-cycle, checked before any clock edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        m_q   = '0;
        m_err = 1'b0;
        m_mis = 1'b0;
        check("rst_out_q", bus.out_q, m_q);
        check("rst_sel_err", W'(bus.sel_err), W'(m_err));
`ifdef PC_SRC_MUX_ALIGN_EN
        check("rst_misalign", W'(bus.misalign), W'(m_mis));
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [W-1:0] A0 = 32'h0000_0004;
    localparam logic [W-1:0] A1 = 32'h0000_1000;
    localparam logic [W-1:0] A2 = 32'h0000_2000;

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.sel = 2'd0;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        m_q   = '0;
        m_err = 1'b0;
        m_mis = 1'b0;
        #12;
        check("init_out_q", bus.out_q, '0);
        check("init_sel_err", W'(bus.sel_err), '0);
        @(negedge clk);
        rst = 1'b0;

        // Select sweep
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 2'(s), A0, A1, A2);
            step();
        end

        // Stall: out follows, out_q holds, then loads
        drive(1'b0, 2'd0, A0, A1, A2);
        step();
        drive(1'b0, 2'd2, A0, A1, A2);
        step();
        drive(1'b1, 2'd2, A0, A1, A2);
        step();

        // Illegal select falls back to in0 and sets sticky flag
        drive(1'b1, 2'd3, A0, A1, A2);
        step();
        drive(1'b1, 2'd0, A0, A1, A2);
        step();
        step();

        // Reset mid-run with out_q = 0x40
        drive(1'b1, 2'd0, 32'h0000_0040, A1, A2);
        step();
        do_reset();

        // Illegal select while stalled does not set the flag
        drive(1'b0, 2'd3, A0, A1, A2);
        step();
        drive(1'b1, 2'd0, A0, A1, A2);
        step();

        // Back-to-back selects
        drive(1'b1, 2'd1, A0, A1, A2);
        step();
        drive(1'b1, 2'd2, A0, A1, A2);
        step();
        drive(1'b1, 2'd0, A0, A1, A2);
        step();

        // Misaligned jump target, then aligned sequential
        drive(1'b1, 2'd1, A0, 32'h0000_1003, A2);
        step();
        drive(1'b1, 2'd0, 32'h0000_0008, A1, A2);
        step();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  W'($urandom), W'($urandom), W'($urandom));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_src_mux3.md
Name: pc_src_mux3

Overview:
- Three-way next-PC source selector for the fetch stage.
- Inputs:
  - in0 = sequential PC+4
  - in1 = jump target
  - in2 = branch target
- Provides a combinational select output, a registered copy with stall enable, and a sticky illegal-select flag.
- Sits between the PC adder/branch/jump logic and the PC register.

Parameters:
- WIDTH, 32, data width of all inputs and outputs.
- RESET_VAL, 32'h0000_0000, value loaded into out_q on reset (truncated/zero-extended to WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  register update enable (0 = stall, hold out_q)
- sel  input  2  source select: 0=in0, 1=in1, 2=in2, 3=illegal
- in0  input  WIDTH  sequential address (PC+4)
- in1  input  WIDTH  jump address
- in2  input  WIDTH  branch address
- out  output  WIDTH  combinational selected value
- out_q  output  WIDTH  registered selected value
- sel_err  output  1  sticky flag: illegal sel seen while en=1

Behaviour:
- Clocking/reset: one clock domain (clk); asynchronous, active-high reset (rst).
- Combinational path (zero latency):
  - out = in0 when sel=0, in1 when sel=1, in2 when sel=2.
  - sel=3 → out = in0 (sequential fallback, fetch never stalls on a bad select).
  - out is purely combinational; it is not affected by rst or en.
- Registered path (1-cycle latency):
  - rst asserted (async, any time, including mid-operation) → out_q = RESET_VAL and sel_err = 0 immediately, held while rst=1.
  - On rising clk with rst=0 and en=1: out_q <= out.
  - en=0: out_q holds its value.
- sel_err:
  - Set on rising clk when rst=0, en=1 and sel=3.
  - Stays set until rst.
  - sel=3 while en=0 does not set it.
- Simultaneous events: rst dominates en and sel. An input change in the same cycle as the clock edge uses the values sampled at that edge.
- Width: no arithmetic. All data paths are exactly WIDTH bits; no sign or zero extension inside the mux.
- First rising edge after rst deasserts: loads normally if en=1.

Optional Feature:
- Macro: PC_SRC_MUX_ALIGN_EN.
- Defined:
  - out has bits [1:0] forced to 0 (word-aligned fetch address); out_q follows from out.
  - Adds output port misalign (1 bit, registered).
  - misalign is set on a rising clk with rst=0, en=1 when the raw selected value has a nonzero [1:0].
  - misalign is non-sticky: it reflects the last loaded value and is cleared to 0 by rst.
- Not defined:
  - out passes the selected value unmodified.
  - misalign port does not exist.

Decomposition:
- Shared package pc_src_pkg:
  - localparams PC_SRC_SEQ=2'd0, PC_SRC_JUMP=2'd1, PC_SRC_BRANCH=2'd2, PC_SRC_ILLEGAL=2'd3.
  - typedef pc_src_t (logic [1:0]).
- One sub-module is natural: pc_src_mux3_dec.
  - Combinational decoder: sel → one-hot select vector plus illegal bit.
  - The top level performs the AND-OR data selection and holds the registers.

Test Plan:
- Reset: assert rst mid-run with out_q=32'h0000_0040 → out_q=32'h0 and sel_err=0 before the next clk edge; release, en=1, sel=0, in0=32'h4 → out_q=32'h4 after one edge.
- Select sweep: in0=32'h0000_0004, in1=32'h0000_1000, in2=32'h0000_2000. sel 0/1/2 → out=4/1000/2000 immediately; out_q matches one edge later.
- Stall: en=0, sel changes 0→2 → out follows to 32'h2000; out_q holds the previous value; en=1 → out_q=32'h2000 next edge.
- Illegal select: sel=3, en=1 → out=in0 (32'h4); sel_err=1 after the edge and stays 1 after sel returns to 0; sel=3 with en=0 on a fresh reset → sel_err stays 0.
- Back-to-back: sel sequence 1,2,0 on consecutive edges with en=1 → out_q = 32'h1000, 32'h2000, 32'h4 on consecutive cycles.
- PC_SRC_MUX_ALIGN_EN build: in1=32'h0000_1003, sel=1 → out=32'h0000_1000; misalign=1 after the edge; next edge with sel=0, in0=32'h8 → misalign=0.
